// File: rtl/ps2_light_decoder.sv
// Turns PS/2 set-2 scan-code bytes into key make/break events and drives eight house lights.
// Event and light update appear 1 cycle after rx_valid; there is no backpressure, so every strobe is consumed.
module ps2_light_decoder #(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  LIGHTS_RESET   = 8'h00
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_break,
    output logic        key_ext,
    output logic [7:0]  lights
);

    localparam int              CW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);

    // The state encoding is the {ext, brk} prefix flag pair.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GOT_F0   = 2'b01,
        GOT_E0   = 2'b10,
        GOT_E0F0 = 2'b11
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      held_q;
    logic [7:0]      lights_q;
    logic            key_valid_q;
    logic [7:0]      key_code_q;
    logic            key_break_q;
    logic            key_ext_q;

    logic            cur_ext;
    logic            cur_brk;
    logic            is_ctrl;
    logic            light_hit;
    logic [2:0]      light_idx;

    assign cur_ext = state_q[1];
    assign cur_brk = state_q[0];

    always_comb begin
        is_ctrl = 1'b0;
        case (rx_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
            default:                                  is_ctrl = 1'b0;
        endcase
    end

    // Digit keys 1..8 map to light indices 0..7.
    always_comb begin
        light_hit = 1'b1;
        light_idx = 3'd0;
        case (rx_data)
            8'h16:   light_idx = 3'd0;
            8'h1E:   light_idx = 3'd1;
            8'h26:   light_idx = 3'd2;
            8'h25:   light_idx = 3'd3;
            8'h2E:   light_idx = 3'd4;
            8'h36:   light_idx = 3'd5;
            8'h3D:   light_idx = 3'd6;
            8'h3E:   light_idx = 3'd7;
            default: light_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            held_q      <= '0;
            lights_q    <= LIGHTS_RESET;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (rx_valid) begin
                cnt_q <= '0;
                if (rx_data == 8'hE0) begin
                    state_q <= state_t'({1'b1, cur_brk});
                end else if (rx_data == 8'hF0) begin
                    state_q <= state_t'({cur_ext, 1'b1});
                end else if (is_ctrl) begin
                    state_q <= IDLE;
                end else begin
                    state_q     <= IDLE;
                    key_valid_q <= 1'b1;
                    key_code_q  <= rx_data;
                    key_break_q <= cur_brk;
                    key_ext_q   <= cur_ext;
                    if (!cur_ext) begin
                        if (light_hit) begin
                            if (cur_brk) begin
                                held_q[light_idx] <= 1'b0;
                            end else if (!held_q[light_idx]) begin
                                // Only the first make of a held key toggles; typematic repeats are ignored.
                                lights_q[light_idx] <= ~lights_q[light_idx];
                                held_q[light_idx]   <= 1'b1;
                            end
                        end else if (!cur_brk && rx_data == 8'h1C) begin
                            lights_q <= 8'hFF;
                        end else if (!cur_brk && rx_data == 8'h1A) begin
                            lights_q <= 8'h00;
                        end
                    end
                end
            end else if (state_q != IDLE) begin
                if (cnt_q == LIMIT) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_break = key_break_q;
    assign key_ext   = key_ext_q;
    assign lights    = lights_q;

endmodule

// File: tb/tb_ps2_light_decoder.sv
// Directed scenarios followed by random byte streams, checked each cycle against a behavioural model.
module tb_ps2_light_decoder;

    localparam int T = 20;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_break;
    logic        key_ext;
    logic [7:0]  lights;

    ps2_light_decoder #(.TIMEOUT_CYCLES(T), .LIGHTS_RESET(8'h00)) dut (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .key_valid(key_valid), .key_code(key_code), .key_break(key_break),
        .key_ext(key_ext), .lights(lights)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: prefix flags, idle gap since the last byte, per-key held bits.
    logic [7:0] m_lights;
    bit         m_held [8];
    bit         m_ext, m_brk;
    int         m_gap;
    bit         m_kv, m_kbrk, m_kext;
    logic [7:0] m_code;

    function automatic int key_to_light(input logic [7:0] b);
        logic [7:0] keys [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
        for (int i = 0; i < 8; i++) if (keys[i] == b) return i;
        return -1;
    endfunction

    task automatic model_step(input bit v, input logic [7:0] d, input bit r);
        int idx;
        m_kv = 0;
        if (!r) begin
            m_lights = 8'h00;
            foreach (m_held[i]) m_held[i] = 0;
            m_ext = 0; m_brk = 0; m_gap = 0;
            m_code = 8'h00; m_kbrk = 0; m_kext = 0;
            return;
        end
        if (!v) begin
            if (m_gap < 1000000) m_gap++;
            return;
        end
        // A prefix left waiting T or more idle cycles has been abandoned.
        if (m_gap >= T) begin m_ext = 0; m_brk = 0; end
        m_gap = 0;
        if (d == 8'hE0) m_ext = 1;
        else if (d == 8'hF0) m_brk = 1;
        else if (d inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin m_ext = 0; m_brk = 0; end
        else begin
            m_kv = 1; m_code = d; m_kbrk = m_brk; m_kext = m_ext;
            if (!m_ext) begin
                idx = key_to_light(d);
                if (idx >= 0) begin
                    if (m_brk) m_held[idx] = 0;
                    else if (!m_held[idx]) begin
                        m_lights[idx] = ~m_lights[idx];
                        m_held[idx] = 1;
                    end
                end else if (!m_brk && d == 8'h1C) m_lights = 8'hFF;
                else if (!m_brk && d == 8'h1A) m_lights = 8'h00;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        @(negedge clock);
        rx_valid = v; rx_data = d; reset_n = r;
        @(posedge clock);
        model_step(v, d, r);
        #1;
        check("key_valid", {31'b0, key_valid}, {31'b0, m_kv});
        check("key_code",  {24'b0, key_code},  {24'b0, m_code});
        check("key_break", {31'b0, key_break}, {31'b0, m_kbrk});
        check("key_ext",   {31'b0, key_ext},   {31'b0, m_kext});
        check("lights",    {24'b0, lights},    {24'b0, m_lights});
    endtask

    task automatic byte_in(input logic [7:0] d);
        cyc(1, d, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 1);
    endtask

    logic [7:0] pool [20] = '{8'hE0, 8'hF0, 8'hF0, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                              8'h36, 8'h3D, 8'h3E, 8'h1C, 8'h1A, 8'h75, 8'h00, 8'hAA,
                              8'hFA, 8'hE0, 8'h16, 8'h3E};

    initial begin
        cyc(0, 8'h00, 0);
        check("rst_lights", {24'b0, lights}, 32'h00);
        check("rst_kv", {31'b0, key_valid}, 32'h0);
        idle(1);

        byte_in(8'h16);
        check("mk16_lights", {24'b0, lights}, 32'h01);
        check("mk16_kv", {31'b0, key_valid}, 32'h1);
        check("mk16_code", {24'b0, key_code}, 32'h16);
        idle(1);
        check("kv_pulse", {31'b0, key_valid}, 32'h0);

        byte_in(8'h1E); byte_in(8'h1E); byte_in(8'h1E);
        check("typematic", {24'b0, lights}, 32'h03);
        byte_in(8'hF0); byte_in(8'h1E);
        check("brk1E_brk", {31'b0, key_break}, 32'h1);
        check("brk1E_lights", {24'b0, lights}, 32'h03);
        byte_in(8'h1E);
        check("remake1E", {24'b0, lights}, 32'h01);

        byte_in(8'hE0); byte_in(8'hF0); byte_in(8'h75);
        check("ext_code", {24'b0, key_code}, 32'h75);
        check("ext_flags", {30'b0, key_ext, key_break}, 32'h3);
        byte_in(8'hE0); byte_in(8'h16);
        check("ext16_lights", {24'b0, lights}, 32'h01);

        byte_in(8'h1C);
        check("all_on", {24'b0, lights}, 32'hFF);
        byte_in(8'hF0); byte_in(8'h1C);
        check("all_on_brk", {24'b0, lights}, 32'hFF);
        byte_in(8'h1A);
        check("all_off", {24'b0, lights}, 32'h00);
        byte_in(8'hF0); byte_in(8'h16);

        byte_in(8'hF0); idle(T); byte_in(8'h16);
        check("timeout_make", {31'b0, key_break}, 32'h0);
        check("timeout_light", {24'b0, lights}, 32'h01);
        byte_in(8'hF0); idle(T - 1); byte_in(8'h16);
        check("expiry_edge_brk", {31'b0, key_break}, 32'h1);

        byte_in(8'hE0); byte_in(8'hF0); cyc(0, 8'h00, 0); byte_in(8'h3E);
        check("rst_mid_flags", {30'b0, key_ext, key_break}, 32'h0);
        check("rst_mid_lights", {24'b0, lights}, 32'h80);
        byte_in(8'hAA);
        check("aa_no_event", {31'b0, key_valid}, 32'h0);

        for (int it = 0; it < 2500; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) cyc(0, 8'h00, 0);
            else if (r < 30) begin
                int g;
                case ($urandom_range(0, 5))
                    0: g = T - 1;
                    1: g = T;
                    2: g = T + 1;
                    default: g = $urandom_range(1, 3);
                endcase
                idle(g);
            end else if (r < 35) byte_in(8'($urandom));
            else byte_in(pool[$urandom_range(0, 19)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
